// File: rtl/compress_sequencer.sv
// Issue sequencer for vcompress: walks the source vector two elements per
// cycle, waits for the offset unit to drain, then reports the packed count.
module compress_sequencer #(
    parameter int VLMAX = 32,
    parameter int IW    = $clog2(VLMAX)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  logic [IW:0]   vl,
    input  logic          abort,
    input  logic          stall,
    output logic [IW-1:0] eidx,
    output logic [1:0]    elem_valid,
    output logic          cou_ena,
    output logic          cou_done,
    input  logic          cou_busy,
    input  logic [1:0]    cou_wen,
    output logic          busy,
    output logic          finish,
    output logic [IW:0]   packed_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam logic [IW:0]   VMAX   = (IW+1)'(VLMAX);
    localparam logic [IW+1:0] VMAX_W = (IW+2)'(VLMAX);

    state_t        state;
    logic [IW:0]   vl_q;
    logic [IW:0]   pair_end;
    logic [IW:0]   upper;
    logic [IW+1:0] cnt_sum;
    logic [IW:0]   cnt_sat;

    assign pair_end = {1'b0, eidx} + (IW+1)'(2);
    assign upper    = {1'b0, eidx} + (IW+1)'(1);
    assign cnt_sum  = {1'b0, packed_cnt}
                    + (IW+2)'(cou_wen[0])
                    + (IW+2)'(cou_wen[1]);
    assign cnt_sat  = (cnt_sum > VMAX_W) ? VMAX : cnt_sum[IW:0];

    // abort suppresses every strobe in the cycle it is seen
    assign cou_ena    = (state == RUN) && !stall && !abort;
    assign cou_done   = (state == DRAIN) && !cou_busy && !abort;
    assign finish     = (state == FIN) && !abort;
    assign busy       = (state != IDLE);
    assign elem_valid = (state == RUN) ? {(upper < vl_q), 1'b1} : 2'b00;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            eidx       <= '0;
            vl_q       <= '0;
            packed_cnt <= '0;
        end else if (abort) begin
            state      <= IDLE;
            eidx       <= '0;
            packed_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        eidx       <= '0;
                        packed_cnt <= '0;
                        vl_q       <= (vl > VMAX) ? VMAX : vl;
                        state      <= (vl == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    packed_cnt <= cnt_sat;
                    if (!stall) begin
                        // last pair: eidx stays on it
                        if (pair_end >= vl_q)
                            state <= DRAIN;
                        else
                            eidx <= eidx + IW'(2);
                    end
                end
                DRAIN: begin
                    packed_cnt <= cnt_sat;
                    if (!cou_busy)
                        state <= FIN;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/compress_sequencer.md
COMPRESS_SEQUENCER -- requirements
Module: compress_sequencer

Interface
REQ-001 The block SHALL have parameter VLMAX, default 32, meaning the maximum vector length in elements (even, >=2).
REQ-002 The block SHALL have parameter IW, default $clog2(VLMAX), meaning the element-index width.
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 nRST  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a vcompress; SHALL be ignored unless in IDLE.
REQ-006 vl  input  IW+1  vector length, sampled when start is accepted.
REQ-007 abort  input  1  flush; SHALL cancel any operation.
REQ-008 stall  input  1  downstream hold; when high, no new element pair SHALL issue.
REQ-009 eidx  output  IW  index of the lower element of the pair being issued (always even).
REQ-010 elem_valid  output  2  per-lane valid for the issued pair: bit0 = element eidx, bit1 = element eidx+1.
REQ-011 cou_ena  output  1  enable to the compress offset unit; one pair is issued per high cycle.
REQ-012 cou_done  output  1  single-cycle end-of-operation strobe to the offset unit.
REQ-013 cou_busy  input  1  offset unit still has writes in flight.
REQ-014 cou_wen  input  2  offset unit per-lane write enables.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 finish  output  1  single-cycle completion pulse.
REQ-017 packed_cnt  output  IW+1  number of elements written; valid while finish is high and held until the next accepted start.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and FIN.
REQ-019 In IDLE, start with vl != 0 SHALL go to RUN and clear eidx and packed_cnt; start with vl == 0 SHALL go directly to FIN with packed_cnt = 0.
REQ-020 In RUN with stall low, the block SHALL assert cou_ena, present eidx/elem_valid, and advance eidx by 2 on the next edge.
REQ-021 In RUN with stall high, cou_ena SHALL be 0 and eidx/elem_valid SHALL hold.
REQ-022 The issued pair SHALL drive elem_valid = 2'b11, except on the last pair of an odd vl, which SHALL drive 2'b01.
REQ-023 When the issued pair satisfies eidx+2 >= vl, the FSM SHALL go to DRAIN on the same edge; eidx SHALL saturate and not advance further.
REQ-024 The first cou_ena SHALL occur one cycle after start is accepted; an unstalled operation SHALL issue exactly ceil(vl/2) consecutive cou_ena cycles.
REQ-025 In DRAIN, when cou_busy is low, the block SHALL assert cou_done for exactly one cycle and go to FIN.
REQ-026 In FIN, the block SHALL assert finish for one cycle and return to IDLE.
REQ-027 In RUN and DRAIN, packed_cnt SHALL add popcount(cou_wen) every cycle; the sum SHALL saturate at VLMAX.
REQ-028 cou_wen SHALL be ignored in IDLE and FIN.
REQ-029 abort SHALL take priority over all other inputs: the FSM SHALL return to IDLE on the next edge, with no finish or cou_done pulse and with eidx and packed_cnt cleared.
REQ-030 A start arriving in the same cycle as abort SHALL be ignored.
REQ-031 A vl greater than VLMAX SHALL be clamped to VLMAX at acceptance.
REQ-032 A stall during DRAIN or FIN SHALL have no effect.

Reset
REQ-033 While nRST is low, the FSM SHALL be in IDLE, and eidx, elem_valid, cou_ena, cou_done, busy, finish and packed_cnt SHALL all be 0.
REQ-034 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge; the first start after nRST rises SHALL be accepted normally.

Verification
REQ-035 vl=8, no stall, cou_wen={01,00,11,10} on the four ena cycles -> cou_ena high for cycles 1-4 with eidx 0,2,4,6; cou_done in cycle 5; finish in cycle 6 with packed_cnt=4.
REQ-036 vl=5 -> three ena cycles, with elem_valid 11, 11, 01 on the last pair at eidx=4.
REQ-037 vl=8, stall high during the second pair for 3 cycles -> eidx=2 held and cou_ena low for 3 cycles, then ena cycles resume; total ena count = 4.
REQ-038 vl=0 -> busy for 1 cycle, finish with packed_cnt=0, and no cou_ena or cou_done.
REQ-039 vl=8, cou_busy held high for 2 cycles after the last pair -> cou_done delayed to the cycle after cou_busy falls.
REQ-040 abort at eidx=4, and separately nRST low during DRAIN -> IDLE with no finish or cou_done pulse and all outputs 0; the next start with vl=2 completes with a single ena cycle.
